// File: rtl/m6502_bus_target_if.sv
// Bus between an arlet6502-style CPU and a memory-mapped target.
// RDY handshake: the CPU presents A/DO/WE and holds them every cycle RDY=0;
// the access is taken on the rising edge that ends the first cycle with RDY=1.
interface m6502_bus_target_if;
   logic [15:0] A;
   logic [7:0]  DO;
   logic        WE;
   logic [7:0]  DI;
   logic        RDY;
   logic        IRQ;
   logic        NMI;
   logic        sel_q;
   logic        dbg_stall;
   logic [2:0]  dbg_wcnt;

   modport master (
      output A, DO, WE,
      input  DI, RDY, IRQ, NMI, sel_q, dbg_stall, dbg_wcnt
   );

   modport slave (
      input  A, DO, WE,
      output DI, RDY, IRQ, NMI, sel_q, dbg_stall, dbg_wcnt
   );
endinterface

// File: rtl/m6502_bus_target.sv
// 16-byte register window on the 6502 bus: wait-state generator, prescaled
// interval timer driving IRQ, and a software-triggered NMI source.
module m6502_bus_target #(
   parameter logic [15:0] BASE_ADDR   = 16'hFE00,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned PRESCALE    = 16
) (
   input logic               clk,
   input logic               reset,
   m6502_bus_target_if.slave bus
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } wstate_t;

   localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);
   localparam logic [2:0]  WAIT_INIT  = NO_WAIT ? 3'd0 : 3'(WAIT_CYCLES - 1);
   localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

   wstate_t     state_q, state_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic        sel;
   logic [3:0]  offset;
   logic        rdy_fsm;
   logic        commit;

   logic        wr, rd;
   logic        wr_reload_lo, wr_reload_hi, wr_ctrl, wr_status, wr_nmi;
   logic        rd_count_lo;
   logic [7:0]  rdata;

   logic [15:0] reload_q;
   logic [15:0] count_q;
   logic [15:0] presc_q;
   logic [7:0]  snap_hi_q;
   logic        en_q, auto_q, ie_q;
   logic        exp_q, nmip_q;
   logic        irq_q, nmi_q;
   logic [7:0]  di_q;
   logic        sel_q_q;
   logic        tick, expire;

   assign sel    = (bus.A[15:4] == BASE_ADDR[15:4]);
   assign offset = bus.A[3:0];

   // Wait-state FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Wait-state FSM: next state
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel && !NO_WAIT) begin
               state_d = ST_STALL;
               wcnt_d  = WAIT_INIT;
            end
         end
         ST_STALL: begin
            if (wcnt_q != 3'd0) wcnt_d = wcnt_q - 3'd1;
            else                state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Wait-state FSM: outputs
   always_comb begin
      rdy_fsm = 1'b1;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy_fsm = NO_WAIT || !sel;
            commit  = NO_WAIT && sel;
         end
         ST_STALL: begin
            rdy_fsm = (wcnt_q == 3'd0);
            commit  = (wcnt_q == 3'd0);
         end
         default: begin
            rdy_fsm = 1'b1;
            commit  = 1'b0;
         end
      endcase
   end

   assign bus.RDY       = reset | rdy_fsm;
   assign bus.dbg_stall = (state_q == ST_STALL);
   assign bus.dbg_wcnt  = wcnt_q;

   assign wr = commit && bus.WE && !reset;
   assign rd = commit && !bus.WE && !reset;

   assign wr_reload_lo = wr && (offset == 4'h0);
   assign wr_reload_hi = wr && (offset == 4'h1);
   assign wr_ctrl      = wr && (offset == 4'h4);
   assign wr_status    = wr && (offset == 4'h5);
   assign wr_nmi       = wr && (offset == 4'h6);
   assign rd_count_lo  = rd && (offset == 4'h2);

   always_comb begin
      rdata = 8'h00;
      case (offset)
         4'h0:    rdata = reload_q[7:0];
         4'h1:    rdata = reload_q[15:8];
         4'h2:    rdata = count_q[7:0];
         4'h3:    rdata = snap_hi_q;
         4'h4:    rdata = {5'b0, ie_q, auto_q, en_q};
         4'h5:    rdata = {6'b0, nmip_q, exp_q};
         default: rdata = 8'h00;
      endcase
   end

   // A CTRL write in the same cycle as a tick takes precedence over the tick.
   assign tick   = en_q && (presc_q == PRESC_LAST) && !wr_ctrl;
   assign expire = tick && (count_q == 16'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         reload_q <= 16'd0;
         count_q  <= 16'd0;
         presc_q  <= 16'd0;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
         ie_q     <= 1'b0;
      end else begin
         if (wr_reload_lo) reload_q[7:0]  <= bus.DO;
         if (wr_reload_hi) reload_q[15:8] <= bus.DO;

         if (wr_ctrl) begin
            en_q   <= bus.DO[0];
            auto_q <= bus.DO[1];
            ie_q   <= bus.DO[2];
            if (bus.DO[0]) begin
               count_q <= reload_q;
               presc_q <= 16'd0;
            end
         end else if (en_q) begin
            if (tick) begin
               presc_q <= 16'd0;
               if (count_q == 16'd0) begin
                  if (auto_q) count_q <= reload_q;
                  else        en_q    <= 1'b0;
               end else begin
                  count_q <= count_q - 16'd1;
               end
            end else begin
               presc_q <= presc_q + 16'd1;
            end
         end
      end
   end

   // Status flags: a hardware set beats a same-cycle write-one-to-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q  <= 1'b0;
         nmip_q <= 1'b0;
         irq_q  <= 1'b0;
         nmi_q  <= 1'b0;
      end else begin
         if (expire)                       exp_q <= 1'b1;
         else if (wr_status && bus.DO[0])  exp_q <= 1'b0;

         if (wr_nmi)                       nmip_q <= 1'b1;
         else if (wr_status && bus.DO[1])  nmip_q <= 1'b0;

         irq_q <= exp_q & ie_q;
         nmi_q <= nmip_q;
      end
   end

   // COUNT_LO read snapshots the high byte so a later COUNT_HI read is coherent.
   always_ff @(posedge clk) begin
      if (reset) begin
         di_q      <= 8'h00;
         sel_q_q   <= 1'b0;
         snap_hi_q <= 8'h00;
      end else begin
         sel_q_q <= rd;
         if (rd)          di_q      <= rdata;
         if (rd_count_lo) snap_hi_q <= count_q[15:8];
      end
   end

   assign bus.DI    = di_q;
   assign bus.sel_q = sel_q_q;
   assign bus.IRQ   = irq_q;
   assign bus.NMI   = nmi_q;

endmodule

// File: tb/tb_m6502_bus_target.sv
// Bench for m6502_bus_target: directed timer/NMI/wait-state scenarios plus a
// randomized register-access run checked against a register-map model.
module tb_m6502_bus_target;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  m6502_bus_target_if bus();
  m6502_bus_target_if bus3();

  m6502_bus_target #(.BASE_ADDR(16'hFE00), .WAIT_CYCLES(1), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  m6502_bus_target #(.BASE_ADDR(16'hFE00), .WAIT_CYCLES(3), .PRESCALE(P)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 1000) begin
      tick();
      g++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // driver: one CPU access, stalls while RDY=0, returns just after the commit edge
  task automatic bus_access(input logic [15:0] addr, input logic we, input logic [7:0] data,
                            output int stalls, output int commit_cyc);
    int g;
    stalls = 0;
    g = 0;
    bus.A = addr; bus.WE = we; bus.DO = data;
    #1;
    while (bus.RDY !== 1'b1 && g < 16) begin
      stalls++;
      g++;
      @(posedge clk);
      #2;
    end
    if (g >= 16) begin
      n_cmp++; n_fail++;
      $display("FAIL bus_timeout: addr %h got RDY low for %0d cycles required release", addr, g);
    end
    @(posedge clk);
    #1;
    commit_cyc = cyc;
    bus.A = 16'h0000; bus.WE = 1'b0; bus.DO = 8'h00;
  endtask

  task automatic bus3_access(input logic [15:0] addr, input logic we, input logic [7:0] data,
                             output int stalls);
    int g;
    stalls = 0;
    g = 0;
    bus3.A = addr; bus3.WE = we; bus3.DO = data;
    #1;
    while (bus3.RDY !== 1'b1 && g < 16) begin
      stalls++;
      g++;
      @(posedge clk);
      #2;
    end
    if (g >= 16) begin
      n_cmp++; n_fail++;
      $display("FAIL bus3_timeout: addr %h got RDY low for %0d cycles required release", addr, g);
    end
    @(posedge clk);
    #1;
    bus3.A = 16'h0000; bus3.WE = 1'b0; bus3.DO = 8'h00;
  endtask

  // reference: timer expiry edges and count value seen by an access committing at edge e
  function automatic int expiry_edge(input int start, input int rld, input int k);
    return start + k * (rld + 1) * P;
  endfunction

  function automatic logic [15:0] count_at(input int start, input int rld, input int e);
    return 16'(rld - (e - 1 - start) / P);
  endfunction

  task automatic test_reset();
    int st, cc;
    do_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", bus.RDY); end
    n_cmp++; if (bus.DI !== 8'h00) begin n_fail++; $display("FAIL reset_di: got %h required 00", bus.DI); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", bus.IRQ); end
    n_cmp++; if (bus.NMI !== 1'b0) begin n_fail++; $display("FAIL reset_nmi: got %b required 0", bus.NMI); end
    n_cmp++; if (bus.sel_q !== 1'b0) begin n_fail++; $display("FAIL reset_selq: got %b required 0", bus.sel_q); end
    tick();
    reset = 1'b0;
    bus_access(16'hFE04, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_read: got %h required 00", bus.DI); end
    n_cmp++; if (bus.sel_q !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl_selq: got %b required 1", bus.sel_q); end
  endtask

  task automatic test_wait_states();
    int st, cc;
    bus_access(16'hFE00, 1'b1, 8'h5A, st, cc);
    n_cmp++; if (st != 1) begin n_fail++; $display("FAIL wait_write_stalls: got %0d required 1", st); end
    bus_access(16'hFE00, 1'b0, 8'h00, st, cc);
    n_cmp++; if (st != 1) begin n_fail++; $display("FAIL wait_read_stalls: got %0d required 1", st); end
    n_cmp++; if (bus.DI !== 8'h5A) begin n_fail++; $display("FAIL wait_read_di: got %h required 5a", bus.DI); end
    n_cmp++; if (bus.sel_q !== 1'b1) begin n_fail++; $display("FAIL wait_read_selq: got %b required 1", bus.sel_q); end
    tick();
    n_cmp++; if (bus.sel_q !== 1'b0) begin n_fail++; $display("FAIL wait_selq_drop: got %b required 0", bus.sel_q); end
    n_cmp++; if (bus.DI !== 8'h5A) begin n_fail++; $display("FAIL wait_di_hold: got %h required 5a", bus.DI); end
    bus_access(16'hFE20, 1'b0, 8'h00, st, cc);
    n_cmp++; if (st != 0) begin n_fail++; $display("FAIL wait_other_stalls: got %0d required 0", st); end
    n_cmp++; if (bus.sel_q !== 1'b0) begin n_fail++; $display("FAIL wait_other_selq: got %b required 0", bus.sel_q); end
    n_cmp++; if (bus.DI !== 8'h5A) begin n_fail++; $display("FAIL wait_other_di: got %h required 5a", bus.DI); end
  endtask

  task automatic test_oneshot();
    int st, cc, c0, irq_cyc, want;
    bus_access(16'hFE00, 1'b1, 8'h03, st, cc);
    bus_access(16'hFE01, 1'b1, 8'h00, st, cc);
    bus_access(16'hFE05, 1'b1, 8'h03, st, cc);
    bus_access(16'hFE04, 1'b1, 8'h05, st, c0);
    want = expiry_edge(c0, 3, 1) + 1;
    irq_cyc = -1;
    for (int g = 0; g < 200; g++) begin
      if (bus.IRQ === 1'b1) begin
        irq_cyc = cyc;
        break;
      end
      tick();
    end
    n_cmp++; if (irq_cyc != want) begin n_fail++; $display("FAIL oneshot_irq_cycle: got %0d required %0d", irq_cyc, want); end
    bus_access(16'hFE04, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h04) begin n_fail++; $display("FAIL oneshot_en_clear: got %h required 04", bus.DI); end
    bus_access(16'hFE05, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h01) begin n_fail++; $display("FAIL oneshot_status: got %h required 01", bus.DI); end
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
    tick();
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_drop: got %b required 0", bus.IRQ); end
    bus_access(16'hFE05, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h00) begin n_fail++; $display("FAIL oneshot_status_clr: got %h required 00", bus.DI); end
  endtask

  task automatic test_auto_reload();
    int st, cc, c0, e1, e2, clr1, clr2;
    bus_access(16'hFE00, 1'b1, 8'h01, st, cc);
    bus_access(16'hFE01, 1'b1, 8'h00, st, cc);
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
    bus_access(16'hFE04, 1'b1, 8'h07, st, c0);
    e1 = expiry_edge(c0, 1, 1);
    e2 = expiry_edge(c0, 1, 2);
    wait_until(e1);
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL auto_irq_early: got %b required 0", bus.IRQ); end
    wait_until(e1 + 1);
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL auto_irq_first: got %b required 1", bus.IRQ); end
    clr1 = e1 + 3;
    wait_until(clr1 - 2);
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
    n_cmp++; if (cc != clr1) begin n_fail++; $display("FAIL auto_clr1_edge: got %0d required %0d", cc, clr1); end
    wait_until(clr1 + 1);
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL auto_clr1_irq: got %b required 0", bus.IRQ); end
    wait_until(e2 + 1);
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL auto_irq_second: got %b required 1", bus.IRQ); end
    clr2 = expiry_edge(c0, 1, 3);
    wait_until(clr2 - 2);
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
    n_cmp++; if (cc != clr2) begin n_fail++; $display("FAIL auto_clr2_edge: got %0d required %0d", cc, clr2); end
    wait_until(clr2 + 1);
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL auto_set_wins: got %b required 1", bus.IRQ); end
    bus_access(16'hFE04, 1'b1, 8'h00, st, cc);
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
  endtask

  task automatic test_atomic_count();
    int st, cc, c0, e;
    logic [15:0] cnt;
    bus_access(16'hFE00, 1'b1, 8'h00, st, cc);
    bus_access(16'hFE01, 1'b1, 8'h01, st, cc);
    bus_access(16'hFE04, 1'b1, 8'h01, st, c0);
    e = c0 + P;
    wait_until(e - 2);
    bus_access(16'hFE02, 1'b0, 8'h00, st, cc);
    cnt = count_at(c0, 16'h0100, cc);
    n_cmp++; if (bus.DI !== cnt[7:0]) begin n_fail++; $display("FAIL atomic_lo: got %h required %h", bus.DI, cnt[7:0]); end
    bus_access(16'hFE03, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== cnt[15:8]) begin n_fail++; $display("FAIL atomic_hi: got %h required %h", bus.DI, cnt[15:8]); end
    bus_access(16'hFE02, 1'b0, 8'h00, st, cc);
    cnt = count_at(c0, 16'h0100, cc);
    n_cmp++; if (bus.DI !== cnt[7:0]) begin n_fail++; $display("FAIL atomic_decr: got %h required %h", bus.DI, cnt[7:0]); end
    bus_access(16'hFE04, 1'b1, 8'h00, st, cc);
  endtask

  task automatic test_nmi();
    int st, cc;
    bus_access(16'hFE06, 1'b1, 8'($urandom_range(0, 255)), st, cc);
    tick();
    n_cmp++; if (bus.NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_set: got %b required 1", bus.NMI); end
    bus_access(16'hFE05, 1'b1, 8'h01, st, cc);
    tick();
    n_cmp++; if (bus.NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_hold: got %b required 1", bus.NMI); end
    bus_access(16'hFE06, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h00) begin n_fail++; $display("FAIL nmi_trig_read: got %h required 00", bus.DI); end
    bus_access(16'hFE05, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h02) begin n_fail++; $display("FAIL nmi_status: got %h required 02", bus.DI); end
    bus_access(16'hFE05, 1'b1, 8'h02, st, cc);
    tick();
    n_cmp++; if (bus.NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_clear: got %b required 0", bus.NMI); end
  endtask

  task automatic test_random_access();
    int st, cc;
    logic [15:0] reload_m;
    logic [2:0]  ctrl_m;
    logic        nmip_m;
    logic [7:0]  snap_m, di_m, want;
    logic [15:0] addr;
    logic [3:0]  off;
    logic        inwin, we;
    logic [7:0]  data;
    do_reset();
    reload_m = 16'h0000; ctrl_m = 3'b000; nmip_m = 1'b0; snap_m = 8'h00; di_m = 8'h00;
    for (int i = 0; i < 40; i++) begin
      inwin = ($urandom_range(0, 9) < 7);
      if (inwin) begin
        off = 4'($urandom_range(0, 15));
        addr = {12'hFE0, off};
      end else begin
        addr = 16'($urandom_range(0, 65535));
        if (addr[15:4] == 12'hFE0) addr = addr ^ 16'h0100;
        off = addr[3:0];
      end
      we = 1'($urandom_range(0, 1));
      data = 8'($urandom_range(0, 255));
      if (inwin && off == 4'h4) data[0] = 1'b0;
      bus_access(addr, we, data, st, cc);
      n_cmp++; if (st != (inwin ? 1 : 0)) begin n_fail++; $display("FAIL rand_stalls[%0d]: addr %h got %0d required %0d", i, addr, st, inwin ? 1 : 0); end
      if (inwin && !we) begin
        case (off)
          4'h0: want = reload_m[7:0];
          4'h1: want = reload_m[15:8];
          4'h3: want = snap_m;
          4'h4: want = {5'b0, ctrl_m};
          4'h5: want = {6'b0, nmip_m, 1'b0};
          default: want = 8'h00;
        endcase
        if (off == 4'h2) snap_m = 8'h00;
        di_m = want;
      end
      if (inwin && we) begin
        case (off)
          4'h0: reload_m[7:0] = data;
          4'h1: reload_m[15:8] = data;
          4'h4: ctrl_m = data[2:0];
          4'h5: if (data[1]) nmip_m = 1'b0;
          4'h6: nmip_m = 1'b1;
          default: ;
        endcase
      end
      n_cmp++; if (bus.DI !== di_m) begin n_fail++; $display("FAIL rand_di[%0d]: addr %h got %h required %h", i, addr, bus.DI, di_m); end
      n_cmp++; if (bus.sel_q !== (inwin && !we)) begin n_fail++; $display("FAIL rand_selq[%0d]: addr %h got %b required %b", i, addr, bus.sel_q, inwin && !we); end
      tick();
      n_cmp++; if (bus.NMI !== nmip_m) begin n_fail++; $display("FAIL rand_nmi[%0d]: got %b required %b", i, bus.NMI, nmip_m); end
    end
  endtask

  task automatic test_wait3();
    int st;
    bus3_access(16'hFE01, 1'b1, 8'hC3, st);
    n_cmp++; if (st != 3) begin n_fail++; $display("FAIL wait3_write_stalls: got %0d required 3", st); end
    bus3_access(16'hFE01, 1'b0, 8'h00, st);
    n_cmp++; if (st != 3) begin n_fail++; $display("FAIL wait3_read_stalls: got %0d required 3", st); end
    n_cmp++; if (bus3.DI !== 8'hC3) begin n_fail++; $display("FAIL wait3_read_di: got %h required c3", bus3.DI); end
    bus3_access(16'h1234, 1'b0, 8'h00, st);
    n_cmp++; if (st != 0) begin n_fail++; $display("FAIL wait3_other_stalls: got %0d required 0", st); end
  endtask

  task automatic test_reset_in_stall();
    int st, cc;
    bus_access(16'hFE00, 1'b1, 8'h11, st, cc);
    bus.A = 16'hFE00; bus.WE = 1'b1; bus.DO = 8'hAA;
    #1;
    n_cmp++; if (bus.RDY !== 1'b0) begin n_fail++; $display("FAIL rststall_pre_rdy: got %b required 0", bus.RDY); end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.RDY !== 1'b1) begin n_fail++; $display("FAIL rststall_forced_rdy: got %b required 1", bus.RDY); end
    tick();
    reset = 1'b0;
    bus.A = 16'h0000; bus.WE = 1'b0; bus.DO = 8'h00;
    #1;
    n_cmp++; if (bus.RDY !== 1'b1) begin n_fail++; $display("FAIL rststall_post_rdy: got %b required 1", bus.RDY); end
    tick();
    bus_access(16'hFE00, 1'b0, 8'h00, st, cc);
    n_cmp++; if (bus.DI !== 8'h00) begin n_fail++; $display("FAIL rststall_reg: got %h required 00", bus.DI); end
  endtask

  initial begin
    bus.A = 16'h0000; bus.WE = 1'b0; bus.DO = 8'h00;
    bus3.A = 16'h0000; bus3.WE = 1'b0; bus3.DO = 8'h00;
    test_reset();
    test_wait_states();
    test_oneshot();
    test_auto_reload();
    test_atomic_count();
    test_nmi();
    test_random_access();
    test_wait3();
    test_reset_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
